dmem_arbiter: RTL and testbench

- Two-port arbiter and access sequencer in front of the single-ported data memory (byte/halfword/word load/store, combinational read, write on posedge).
- Shares the memory between port 0 (CPU load/store unit) and port 1 (debug/loader).
- Uses round-robin arbitration and a fixed 3-state access sequence.
- Returns read data and a completion ack to the granted requester.

---
 rtl/dmem_arbiter_if.sv | 45 ++++
 rtl/dmem_arbiter.sv | 140 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Request/response bus for dmem_arbiter.
// Carries both requester ports and the data-memory side. The slave modport is
// the arbiter's view. The master modport is the environment's view (the two
// requesters plus the memory).
interface dmem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  // Requester port 0 (CPU LSU) and port 1 (debug/loader)
  logic              req0, req1;
  logic              we0, we1;
  logic [1:0]        lsc0, lsc1;
  logic              sx0, sx1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              ack0, ack1;
  logic              err0, err1;
  logic [DATA_W-1:0] rdata;
  // Memory side
  logic              mem_read;
  logic              mem_write;
  logic [1:0]        mem_lsc;
  logic              mem_sx;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  // Status
  logic              busy;

  modport slave (
    input  req0, req1, we0, we1, lsc0, lsc1, sx0, sx1, addr0, addr1, wdata0, wdata1,
    input  mem_rdata,
    output ack0, ack1, err0, err1, rdata,
    output mem_read, mem_write, mem_lsc, mem_sx, mem_addr, mem_wdata,
    output busy
  );

  modport master (
    output req0, req1, we0, we1, lsc0, lsc1, sx0, sx1, addr0, addr1, wdata0, wdata1,
    output mem_rdata,
    input  ack0, ack1, err0, err1, rdata,
    input  mem_read, mem_write, mem_lsc, mem_sx, mem_addr, mem_wdata,
    input  busy
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and access sequencer for a single-ported data memory.
// Sequence: IDLE (grant and latch command) -> ACCESS (one memory cycle) -> RESP (ack).
// Illegal commands go straight from IDLE to RESP with err set and no memory cycle.
// Optional macro DMEM_ARB_ALIGN_CHECK_EN also rejects misaligned halfword and word
// accesses.
module dmem_arbiter #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned PRIO_INIT = 0
) (
  input  logic          clock,
  input  logic          reset_n,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e            state_q, state_d;
  logic              prio_q, prio_d;
  logic              owner_q, owner_d;
  logic              err_q, err_d;
  logic              we_q, we_d;
  logic [1:0]        lsc_q, lsc_d;
  logic              sx_q, sx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              grant;
  logic              win;
  logic              sel_we;
  logic [1:0]        sel_lsc;
  logic              sel_sx;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              legal;

  // Pick the winner and mux its command fields; prio only matters on a tie
  always_comb begin
    grant     = bus.req0 | bus.req1;
    win       = (bus.req0 & bus.req1) ? prio_q : bus.req1;
    sel_we    = win ? bus.we1    : bus.we0;
    sel_lsc   = win ? bus.lsc1   : bus.lsc0;
    sel_sx    = win ? bus.sx1    : bus.sx0;
    sel_addr  = win ? bus.addr1  : bus.addr0;
    sel_wdata = win ? bus.wdata1 : bus.wdata0;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    legal = (sel_lsc != 2'd3) &&
            !((sel_lsc == 2'd1) && sel_addr[0]) &&
            !((sel_lsc == 2'd2) && (sel_addr[1:0] != 2'b00));
`else
    legal = (sel_lsc != 2'd3);
`endif
  end

  // Next-state logic for the access sequencer and command registers
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    owner_d = owner_q;
    err_d   = err_q;
    we_d    = we_q;
    lsc_d   = lsc_q;
    sx_d    = sx_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      StIdle: begin
        if (grant) begin
          owner_d = win;
          prio_d  = ~win;
          we_d    = sel_we;
          lsc_d   = sel_lsc;
          sx_d    = sel_sx;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          // Cleared here so rejected accesses and stores return zero
          rdata_d = '0;
          err_d   = ~legal;
          state_d = legal ? StAccess : StResp;
        end
      end
      StAccess: begin
        rdata_d = we_q ? '0 : bus.mem_rdata;
        state_d = StResp;
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and command registers; reset aborts any access in flight
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      prio_q  <= PRIO_INIT[0];
      owner_q <= 1'b0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      lsc_q   <= 2'd0;
      sx_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      owner_q <= owner_d;
      err_q   <= err_d;
      we_q    <= we_d;
      lsc_q   <= lsc_d;
      sx_q    <= sx_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Outputs: strobes only in ACCESS, ack to the owner only in RESP
  always_comb begin
    bus.mem_read  = (state_q == StAccess) & ~we_q;
    bus.mem_write = (state_q == StAccess) & we_q;
    bus.mem_lsc   = lsc_q;
    bus.mem_sx    = sx_q;
    bus.mem_addr  = addr_q;
    bus.mem_wdata = wdata_q;
    bus.ack0      = (state_q == StResp) & ~owner_q;
    bus.ack1      = (state_q == StResp) & owner_q;
    bus.err0      = (state_q == StResp) & ~owner_q & err_q;
    bus.err1      = (state_q == StResp) & owner_q & err_q;
    bus.rdata     = rdata_q;
    bus.busy      = (state_q != StIdle);
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a table of single transactions plus
// hand-written sequences for priority, contention and reset during an access.
// The bench provides a big-endian byte/halfword/word memory.
module tb_dmem_arbiter;

  logic clock;
  logic reset_n;

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  dmem_arbiter #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .PRIO_INIT(0)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory model: 64 words, big-endian, low address bits ignored per size
  logic [31:0] mem [64] = '{4: 32'h8899AABB, default: 32'h0};

  function automatic logic [31:0] mem_rd(logic [31:0] a, logic [1:0] lsc, logic sx,
                                         logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> (8 * (3 - int'(a[1:0]))));
    h = 16'(w >> (16 * (1 - int'(a[1]))));
    case (lsc)
      2'd0:    return sx ? {{24{b[7]}}, b} : {24'h0, b};
      2'd1:    return sx ? {{16{h[15]}}, h} : {16'h0, h};
      2'd2:    return w;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] mem_wr(logic [31:0] a, logic [1:0] lsc, logic [31:0] w,
                                         logic [31:0] d);
    int sh;
    case (lsc)
      2'd0: begin
        sh = 8 * (3 - int'(a[1:0]));
        return (w & ~(32'hFF << sh)) | ((d & 32'hFF) << sh);
      end
      2'd1: begin
        sh = 16 * (1 - int'(a[1]));
        return (w & ~(32'hFFFF << sh)) | ((d & 32'hFFFF) << sh);
      end
      2'd2:    return d;
      default: return w;
    endcase
  endfunction

  always_comb bus.mem_rdata = mem_rd(bus.mem_addr, bus.mem_lsc, bus.mem_sx,
                                     mem[bus.mem_addr[7:2]]);

  always @(posedge clock) begin
    if (bus.mem_write)
      mem[bus.mem_addr[7:2]] <= mem_wr(bus.mem_addr, bus.mem_lsc, mem[bus.mem_addr[7:2]],
                                       bus.mem_wdata);
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic        port;
    logic        we;
    logic [1:0]  lsc;
    logic        sx;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
  } vec_t;

  function automatic vec_t mk(string n, logic p, logic we, logic [1:0] lsc, logic sx,
                              logic [31:0] a, logic [31:0] wd, logic [31:0] er, logic ee,
                              int lat, int rd, int wr);
    vec_t v;
    v.name = n; v.port = p; v.we = we; v.lsc = lsc; v.sx = sx; v.addr = a; v.wdata = wd;
    v.exp_rdata = er; v.exp_err = ee; v.exp_lat = lat; v.exp_rd = rd; v.exp_wr = wr;
    return v;
  endfunction

  task automatic set_port(input logic p, input logic req, input vec_t v);
    if (p) begin
      bus.we1 = v.we; bus.lsc1 = v.lsc; bus.sx1 = v.sx; bus.addr1 = v.addr;
      bus.wdata1 = v.wdata; bus.req1 = req;
    end else begin
      bus.we0 = v.we; bus.lsc0 = v.lsc; bus.sx0 = v.sx; bus.addr0 = v.addr;
      bus.wdata0 = v.wdata; bus.req0 = req;
    end
  endtask

  // One transaction on v.port; latency counted from the IDLE cycle that samples req
  task automatic run_and_check(input vec_t v);
    logic        got, other, resp_ctl, er;
    logic [31:0] rd, maddr;
    int          lat, nrd, nwr;
    got = 0; other = 0; resp_ctl = 0; er = 0; rd = '0; maddr = '0;
    lat = -1; nrd = 0; nwr = 0;
    @(posedge clock); #1;
    set_port(v.port, 1'b1, v);
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clock);
      if (bus.mem_read) nrd++;
      if (bus.mem_write) nwr++;
      if (bus.mem_read || bus.mem_write) maddr = bus.mem_addr;
      if (v.port ? bus.ack0 : bus.ack1) other = 1;
      if (v.port ? bus.ack1 : bus.ack0) begin
        got = 1; lat = k; rd = bus.rdata; er = v.port ? bus.err1 : bus.err0;
        resp_ctl = bus.mem_read | bus.mem_write;
      end
    end
    @(posedge clock); #1;
    if (v.port) bus.req1 = 1'b0; else bus.req0 = 1'b0;
    check({v.name, ".ack_seen"}, 32'(got), 32'd1);
    if (got) begin
      check({v.name, ".rdata"}, rd, v.exp_rdata);
      check({v.name, ".err"}, 32'(er), 32'(v.exp_err));
      check({v.name, ".latency"}, 32'(lat), 32'(v.exp_lat));
      check({v.name, ".mem_read_cycles"}, 32'(nrd), 32'(v.exp_rd));
      check({v.name, ".mem_write_cycles"}, 32'(nwr), 32'(v.exp_wr));
      check({v.name, ".other_ack"}, 32'(other), 32'd0);
      check({v.name, ".resp_strobes"}, 32'(resp_ctl), 32'd0);
      if (v.exp_rd + v.exp_wr > 0) check({v.name, ".mem_addr"}, maddr, v.addr);
    end
  endtask

  task automatic reset_assert();
    @(posedge clock); #1;
    reset_n = 1'b0;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
  endtask

  task automatic reset_release();
    @(posedge clock); #1;
    reset_n = 1'b1;
  endtask

  vec_t vecs[15];
  vec_t idle_v;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t        va, vb;
    logic        found;
    int          first, nack, nev;
    int          ev_port[4], ev_cyc[4];
    logic [31:0] ev_rd[4], first_rd;
    logic        both;

    // Addresses 0x10: 8899AABB, later 8899BEEF; 0x20: 12345678, then 12A55678
    vecs[0]  = mk("ld_b_sx",  0, 0, 2'd0, 1, 32'h10, 32'h0,        32'hFFFFFF88, 0, 2, 1, 0);
    vecs[1]  = mk("ld_b_zx",  0, 0, 2'd0, 0, 32'h11, 32'h0,        32'h00000099, 0, 2, 1, 0);
    vecs[2]  = mk("ld_h_sx",  0, 0, 2'd1, 1, 32'h12, 32'h0,        32'hFFFFAABB, 0, 2, 1, 0);
    vecs[3]  = mk("ld_w_p1",  1, 0, 2'd2, 0, 32'h10, 32'h0,        32'h8899AABB, 0, 2, 1, 0);
    vecs[4]  = mk("st_w_p1",  1, 1, 2'd2, 0, 32'h20, 32'h12345678, 32'h0,        0, 2, 0, 1);
    vecs[5]  = mk("ld_h_p1",  1, 0, 2'd1, 0, 32'h22, 32'h0,        32'h00005678, 0, 2, 1, 0);
    vecs[6]  = mk("st_b_p0",  0, 1, 2'd0, 0, 32'h21, 32'hFFFFFFA5, 32'h0,        0, 2, 0, 1);
    vecs[7]  = mk("ld_w_p0",  0, 0, 2'd2, 0, 32'h20, 32'h0,        32'h12A55678, 0, 2, 1, 0);
    vecs[8]  = mk("ld_h_pos", 0, 0, 2'd1, 1, 32'h20, 32'h0,        32'h000012A5, 0, 2, 1, 0);
    vecs[9]  = mk("ill_ld",   0, 0, 2'd3, 1, 32'h10, 32'h0,        32'h0,        1, 1, 0, 0);
    vecs[10] = mk("ill_st",   1, 1, 2'd3, 0, 32'h20, 32'hFFFFFFFF, 32'h0,        1, 1, 0, 0);
    vecs[11] = mk("ld_after", 0, 0, 2'd2, 0, 32'h20, 32'h0,        32'h12A55678, 0, 2, 1, 0);
    vecs[12] = mk("st_h_p1",  1, 1, 2'd1, 0, 32'h12, 32'h0000BEEF, 32'h0,        0, 2, 0, 1);
    vecs[13] = mk("ld_w_chk", 0, 0, 2'd2, 0, 32'h10, 32'h0,        32'h8899BEEF, 0, 2, 1, 0);
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    vecs[14] = mk("ld_w_mis", 1, 0, 2'd2, 0, 32'h22, 32'h0,        32'h0,        1, 1, 0, 0);
`else
    vecs[14] = mk("ld_w_mis", 1, 0, 2'd2, 0, 32'h22, 32'h0,        32'h12A55678, 0, 2, 1, 0);
`endif

    idle_v = mk("idle", 0, 0, 2'd0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0);
    set_port(1'b0, 1'b0, idle_v);
    set_port(1'b1, 1'b0, idle_v);
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    check("rst.acks", {28'h0, bus.ack0, bus.ack1, bus.err0, bus.err1}, 32'h0);
    check("rst.rdata", bus.rdata, 32'h0);
    check("rst.mem_ctl", {27'h0, bus.mem_read, bus.mem_write, bus.mem_lsc, bus.mem_sx},
          32'h0);
    check("rst.mem_addr", bus.mem_addr, 32'h0);
    check("rst.mem_wdata", bus.mem_wdata, 32'h0);
    check("rst.busy", 32'(bus.busy), 32'h0);
    reset_release();

    for (int i = 0; i < 15; i++) run_and_check(vecs[i]);

    // Illegal grant to port 0 must still hand priority to port 1
    reset_assert();
    reset_release();
    run_and_check(mk("ill_prio", 0, 0, 2'd3, 0, 32'h10, 32'h0, 32'h0, 1, 1, 0, 0));
    va = mk("a", 0, 0, 2'd2, 0, 32'h10, 32'h0, 32'h0, 0, 0, 0, 0);
    vb = mk("b", 1, 0, 2'd2, 0, 32'h20, 32'h0, 32'h0, 0, 0, 0, 0);
    @(posedge clock); #1;
    set_port(1'b0, 1'b1, va);
    set_port(1'b1, 1'b1, vb);
    first = -1; first_rd = '0;
    for (int k = 0; k < 6 && first < 0; k++) begin
      @(negedge clock);
      if (bus.ack0 || bus.ack1) begin
        first = bus.ack1 ? 1 : 0;
        first_rd = bus.rdata;
      end
    end
    @(posedge clock); #1;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    check("prio.first_port", 32'(first), 32'd1);
    check("prio.rdata", first_rd, 32'h12A55678);

    // Both ports requesting continuously from reset: strict 0,1,0,1 every 3 cycles
    reset_assert();
    set_port(1'b0, 1'b1, va);
    set_port(1'b1, 1'b1, vb);
    reset_release();
    nev = 0; both = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      if (bus.ack0 && bus.ack1) both = 1;
      if ((bus.ack0 || bus.ack1) && nev < 4) begin
        ev_port[nev] = bus.ack1 ? 1 : 0;
        ev_cyc[nev]  = k;
        ev_rd[nev]   = bus.rdata;
        nev++;
      end
    end
    @(posedge clock); #1;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    check("rr.ack_count", 32'(nev), 32'd4);
    check("rr.both_acks", 32'(both), 32'd0);
    for (int i = 0; i < nev; i++) begin
      check($sformatf("rr.port[%0d]", i), 32'(ev_port[i]), 32'(i % 2));
      check($sformatf("rr.cycle[%0d]", i), 32'(ev_cyc[i]), 32'(2 + 3 * i));
      check($sformatf("rr.rdata[%0d]", i), ev_rd[i],
            (i % 2 == 1) ? 32'h12A55678 : 32'h8899BEEF);
    end

    // Reset during the ACCESS cycle of a store: no ack, no commit
    @(posedge clock); #1;
    set_port(1'b1, 1'b1, mk("st", 1, 1, 2'd2, 0, 32'h30, 32'hDEADBEEF, 32'h0, 0, 0, 0, 0));
    found = 0;
    for (int k = 0; k < 6 && !found; k++) begin
      @(negedge clock);
      if (bus.mem_write) found = 1;
    end
    check("rst_mid.access_seen", 32'(found), 32'd1);
    reset_n = 1'b0;
    bus.req1 = 1'b0;
    #1;
    check("rst_mid.acks", {30'h0, bus.ack0, bus.ack1}, 32'h0);
    check("rst_mid.strobes", {30'h0, bus.mem_read, bus.mem_write}, 32'h0);
    check("rst_mid.busy", 32'(bus.busy), 32'h0);
    check("rst_mid.mem_addr", bus.mem_addr, 32'h0);
    check("rst_mid.rdata", bus.rdata, 32'h0);
    @(posedge clock); #1;
    check("rst_mid.no_commit", mem[12], 32'h0);
    reset_release();
    nack = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      if (bus.ack0 || bus.ack1) nack++;
    end
    check("rst_mid.no_ack", 32'(nack), 32'd0);
    run_and_check(mk("post_rst_ld", 1, 0, 2'd2, 0, 32'h30, 32'h0, 32'h0, 0, 2, 1, 0));
    run_and_check(mk("post_rst_st", 1, 1, 2'd2, 0, 32'h30, 32'hCAFEF00D, 32'h0, 0, 2, 0, 1));
    run_and_check(mk("post_rst_rb", 0, 0, 2'd2, 0, 32'h30, 32'h0, 32'hCAFEF00D, 0, 2, 1, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
